// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/div_ratio_monitor_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus an edge-detect stage.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/div_ratio_monitor.sv
// Measures period/high time of a divided clock and checks the period against exp_ratio.
// Build option: define DUTY_CHECK_EN to also require high_time of floor(N/2) or ceil(N/2).
module div_ratio_monitor
    import div_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_ratio,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] SAT  = CNT_W'(sat_max(CNT_W));
    localparam int unsigned      MC_W = $clog2(LOCK_N + 1);
    localparam logic [MC_W-1:0]  MC_MAX = MC_W'(LOCK_N);

    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [MC_W-1:0]  match_cnt;
    logic             publish;
    logic             latch_hi;
    logic             to_hit;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] period_nxt;
    logic             period_ok;
    logic             is_match;

    edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (div_in),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // An edge always wins over saturation, since it restarts cnt in the same cycle.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = HIGH;
                HIGH: begin
                    if (fall)                     state_nxt = LOW;
                    else if (!rise && cnt == SAT) state_nxt = IDLE;
                end
                LOW: begin
                    if (rise)                     state_nxt = HIGH;
                    else if (!fall && cnt == SAT) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        publish  = en && (state == LOW) && rise;
        latch_hi = en && (state == HIGH) && fall;
        to_hit   = en && (state != IDLE) && (cnt == SAT) && !rise && !fall;
    end

    always_comb begin
        sum        = {1'b0, hi_cnt} + {1'b0, cnt};
        period_nxt = sum[CNT_W] ? SAT : sum[CNT_W-1:0];
        period_ok  = !sum[CNT_W] && (period_nxt == exp_ratio) && (exp_ratio >= CNT_W'(2));
    end

`ifdef DUTY_CHECK_EN
    logic [CNT_W:0] half_lo;
    logic [CNT_W:0] half_hi;
    logic           duty_ok;

    always_comb begin
        half_lo  = {1'b0, exp_ratio} >> 1;
        half_hi  = ({1'b0, exp_ratio} + (CNT_W + 1)'(1)) >> 1;
        duty_ok  = ({1'b0, hi_cnt} == half_lo) || ({1'b0, hi_cnt} == half_hi);
        is_match = period_ok && duty_ok;
    end
`else
    always_comb begin
        is_match = period_ok;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            hi_cnt     <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            match_cnt  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= publish;
            mismatch   <= publish && !is_match;

            if (rise || fall)    cnt <= CNT_W'(1);
            else if (cnt != SAT) cnt <= cnt + CNT_W'(1);

            if (latch_hi) hi_cnt <= cnt;

            if (rise)        timeout <= 1'b0;
            else if (to_hit) timeout <= 1'b1;

            if (to_hit) begin
                match_cnt <= '0;
                locked    <= 1'b0;
            end else if (publish) begin
                period    <= period_nxt;
                high_time <= hi_cnt;
                if (is_match) begin
                    if (match_cnt != MC_MAX)         match_cnt <= match_cnt + MC_W'(1);
                    if (match_cnt >= MC_MAX - MC_W'(1)) locked <= 1'b1;
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end
        end
    end

endmodule
